// File: rtl/display_driver_scan_ctrl.sv
// Scan sequencer for a HUB75-style panel feeding display_driver_rgb_pipe.
// Optional macro SCAN_CTRL_BRIGHTNESS_EN adds a global brightness input.
module display_driver_scan_ctrl #(
    parameter int columns     = 64,
    parameter int rows        = 16,
    parameter int bitwidth    = 8,
    parameter int pipe_length = 2,
    parameter int oe_base     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef SCAN_CTRL_BRIGHTNESS_EN
    input  logic [7:0]                  brightness,
`endif
    output logic [$clog2(columns)-1:0]  col,
    output logic [$clog2(rows)-1:0]     row,
    output logic [$clog2(bitwidth)-1:0] select,
    output logic                        go,
    output logic                        panel_clk,
    output logic                        panel_lat,
    output logic                        panel_oe_n,
    output logic [$clog2(rows)-1:0]     panel_addr,
    output logic                        frame_start
);

    localparam int CW    = $clog2(columns);
    localparam int RW    = $clog2(rows);
    localparam int BW    = $clog2(bitwidth);
    localparam int TW    = $clog2(oe_base) + bitwidth;
    localparam int SLOTS = columns + pipe_length;
    localparam int KW    = $clog2(SLOTS + 1);

    typedef enum logic [1:0] {
        SHIFT,
        WAIT,
        BLANK,
        LATCH
    } state_t;

    // Sequencing registers run one cycle ahead of the output registers,
    // so every output is a registered decode of the sequencer position.
    state_t        st_q, st_d;
    logic [KW-1:0] slot_q, slot_d;
    logic          ph_q, ph_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic [BW-1:0] sel_cnt_q, sel_cnt_d;
    logic [RW-1:0] addr_cnt_q, addr_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          oe_on;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q;
    logic [BW-1:0] select_q;
    logic          go_q, go_d;
    logic          pclk_q, pclk_d;
    logic          plat_q, plat_d;
    logic          poe_n_q, poe_n_d;
    logic [RW-1:0] paddr_q;
    logic          fs_q, fs_d;

`ifdef SCAN_CTRL_BRIGHTNESS_EN
    // Lit-time counter: panel is lit only for the first (P*brightness)>>8
    // cycles of the plane period kept by tmr_q.
    logic [TW-1:0]   on_q, on_d;
    logic [TW+7:0]   on_prod;
    assign on_prod = (TW+8)'(TW'(oe_base) << sel_cnt_q) * (TW+8)'(brightness);
    assign oe_on   = (on_q != '0);
`else
    assign oe_on   = (tmr_q != '0);
`endif

    // Next sequencer position: shift slots, wait for OE expiry, blank, latch.
    always_comb begin
        st_d       = st_q;
        slot_d     = slot_q;
        ph_d       = ph_q;
        row_cnt_d  = row_cnt_q;
        sel_cnt_d  = sel_cnt_q;
        addr_cnt_d = addr_cnt_q;
        tmr_d      = (tmr_q != '0) ? tmr_q - TW'(1) : tmr_q;
`ifdef SCAN_CTRL_BRIGHTNESS_EN
        on_d       = (on_q != '0) ? on_q - TW'(1) : on_q;
`endif
        unique case (st_q)
            SHIFT: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    if (slot_q == KW'(SLOTS - 1)) begin
                        slot_d = '0;
                        st_d   = WAIT;
                    end else begin
                        slot_d = slot_q + KW'(1);
                    end
                end
            end
            WAIT: begin
                if (tmr_q == '0) st_d = BLANK;
            end
            BLANK: begin
                st_d = LATCH;
            end
            LATCH: begin
                st_d       = SHIFT;
                addr_cnt_d = row_cnt_q;
                tmr_d      = TW'(oe_base) << sel_cnt_q;
`ifdef SCAN_CTRL_BRIGHTNESS_EN
                on_d       = on_prod[TW+7:8];
`endif
                if (sel_cnt_q == BW'(bitwidth - 1)) begin
                    sel_cnt_d = '0;
                    row_cnt_d = (row_cnt_q == RW'(rows - 1)) ? '0 : row_cnt_q + RW'(1);
                end else begin
                    sel_cnt_d = sel_cnt_q + BW'(1);
                end
            end
        endcase
    end

    // Output decode of the current sequencer position.
    always_comb begin
        go_d    = (st_q == SHIFT) && !ph_q;
        pclk_d  = (st_q == SHIFT) && !ph_q && (slot_q >= KW'(pipe_length));
        plat_d  = (st_q == LATCH);
        poe_n_d = (st_q == BLANK) || (st_q == LATCH) || !oe_on;
        fs_d    = (st_q == SHIFT) && !ph_q && (slot_q == '0) &&
                  (row_cnt_q == '0) && (sel_cnt_q == '0);
        col_d   = CW'(columns - 1);
        if ((st_q == SHIFT) && (slot_q < KW'(columns))) col_d = CW'(slot_q);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= SHIFT;
            slot_q     <= '0;
            ph_q       <= 1'b0;
            row_cnt_q  <= '0;
            sel_cnt_q  <= '0;
            addr_cnt_q <= '0;
            tmr_q      <= '0;
`ifdef SCAN_CTRL_BRIGHTNESS_EN
            on_q       <= '0;
`endif
            col_q      <= '0;
            row_q      <= '0;
            select_q   <= '0;
            go_q       <= 1'b0;
            pclk_q     <= 1'b0;
            plat_q     <= 1'b0;
            poe_n_q    <= 1'b1;
            paddr_q    <= '0;
            fs_q       <= 1'b0;
        end else begin
            st_q       <= st_d;
            slot_q     <= slot_d;
            ph_q       <= ph_d;
            row_cnt_q  <= row_cnt_d;
            sel_cnt_q  <= sel_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            tmr_q      <= tmr_d;
`ifdef SCAN_CTRL_BRIGHTNESS_EN
            on_q       <= on_d;
`endif
            col_q      <= col_d;
            row_q      <= row_cnt_q;
            select_q   <= sel_cnt_q;
            go_q       <= go_d;
            pclk_q     <= pclk_d;
            plat_q     <= plat_d;
            poe_n_q    <= poe_n_d;
            paddr_q    <= addr_cnt_q;
            fs_q       <= fs_d;
        end
    end

    assign col         = col_q;
    assign row         = row_q;
    assign select      = select_q;
    assign go          = go_q;
    assign panel_clk   = pclk_q;
    assign panel_lat   = plat_q;
    assign panel_oe_n  = poe_n_q;
    assign panel_addr  = paddr_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_display_driver_scan_ctrl.sv
// Directed bench for display_driver_scan_ctrl (4 cols, 2 rows, 2 planes).
// Includes a 2-deep go-advanced rgb pipe model to check panel_clk alignment.
module tb_display_driver_scan_ctrl;

    localparam int NC = 100;
`ifdef SCAN_CTRL_BRIGHTNESS_EN
    localparam int BR = 128;
`else
    localparam int BR = 256;
`endif
    localparam int LOW0 = (16 * BR) >> 8;
    localparam int LOW1 = (32 * BR) >> 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] col;
    logic [0:0] row;
    logic [0:0] select;
    logic       go;
    logic       panel_clk;
    logic       panel_lat;
    logic       panel_oe_n;
    logic [0:0] panel_addr;
    logic       frame_start;

    logic [2:0] p0, p1;

    int total = 0;
    int bad   = 0;

    int a_go[NC], a_clk[NC], a_lat[NC], a_oe[NC], a_fs[NC];
    int a_col[NC], a_row[NC], a_sel[NC], a_addr[NC], a_rgb[NC];

    always #5 clk = ~clk;

    display_driver_scan_ctrl #(
        .columns(4), .rows(2), .bitwidth(2), .pipe_length(2), .oe_base(16)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef SCAN_CTRL_BRIGHTNESS_EN
        .brightness(8'(BR)),
`endif
        .col(col),
        .row(row),
        .select(select),
        .go(go),
        .panel_clk(panel_clk),
        .panel_lat(panel_lat),
        .panel_oe_n(panel_oe_n),
        .panel_addr(panel_addr),
        .frame_start(frame_start)
    );

    // Downstream pipe model: pixel = {plane, column}, two go-advanced stages.
    always @(posedge clk) begin
        if (go) begin
            p0 <= {select, col};
            p1 <= p0;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int c, k, v, n;
        bit found;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_col", int'(col), 0);
        chk("rst_go", int'(go), 0);
        chk("rst_oe_n", int'(panel_oe_n), 1);
        chk("rst_lat_clk_fs", int'({panel_lat, panel_clk, frame_start}), 0);
        chk("rst_row_sel_addr", int'({row, select, panel_addr}), 0);
        rst = 1'b0;

        for (int i = 0; i < NC; i++) begin
            @(negedge clk);
            a_go[i]   = int'(go);
            a_clk[i]  = int'(panel_clk);
            a_lat[i]  = int'(panel_lat);
            a_oe[i]   = int'(panel_oe_n);
            a_fs[i]   = int'(frame_start);
            a_col[i]  = int'(col);
            a_row[i]  = int'(row);
            a_sel[i]  = int'(select);
            a_addr[i] = int'(panel_addr);
            a_rgb[i]  = int'(p1);
        end

        // First shift: cycles 0..11
        c = 0;
        for (int i = 0; i < 12; i++) c += a_go[i];
        chk("shift0_go_count", c, 6);
        chk("shift0_go_phase1", a_go[1], 0);
        for (int s = 0; s < 6; s++)
            chk($sformatf("shift0_col_slot%0d", s), a_col[2*s], (s < 4) ? s : 3);
        c = 0;
        for (int i = 0; i < 12; i++) c += a_clk[i];
        chk("shift0_pclk_count", c, 4);
        chk("shift0_pclk_slot1", a_clk[2], 0);
        chk("shift0_pclk_first", a_clk[4], 1);
        chk("fs_cycle0", a_fs[0], 1);
        chk("shift0_end_go", a_go[12], 0);

        // WAIT 12, BLANK 13, LATCH 14, then plane 1 shift from 15
        chk("lat0_pre", a_lat[13], 0);
        chk("lat0", a_lat[14], 1);
        chk("lat0_oe_n", a_oe[14], 1);
        chk("addr_after_lat0", a_addr[15], 0);
        chk("sel_plane1", a_sel[15], 1);
        chk("row_plane1", a_row[15], 0);
        chk("oe_low_start0", a_oe[15], (LOW0 > 0) ? 0 : 1);
        c = 0;
        for (int i = 15; i < 34; i++) c += 1 - a_oe[i];
        chk("oe_low_plane0", c, LOW0);

        // Plane 1 shift 15..26, WAIT 27..31, BLANK 32, LATCH 33
        c = 0;
        for (int i = 27; i < 32; i++) c += a_go[i] + a_clk[i] + a_lat[i];
        chk("wait_quiet", c, 0);
        chk("lat1_pre", a_lat[32], 0);
        chk("lat1", a_lat[33], 1);
        c = 0;
        for (int i = 34; i < 69; i++) c += 1 - a_oe[i];
        chk("oe_low_plane1", c, LOW1);
        chk("row1_sel0_row", a_row[34], 1);
        chk("row1_sel0_sel", a_sel[34], 0);
        chk("addr_hold", a_addr[68], 0);
        chk("lat2", a_lat[68], 1);
        chk("addr_row1", a_addr[69], 1);
        chk("row1_sel1", a_sel[69], 1);
        c = 0;
        for (int i = 69; i < 88; i++) c += 1 - a_oe[i];
        chk("oe_low_row1_plane0", c, LOW0);
        chk("lat3", a_lat[87], 1);
        chk("wrap_row", a_row[88], 0);
        chk("wrap_fs", a_fs[88], 1);
        c = 0;
        for (int i = 0; i < NC; i++) c += a_fs[i];
        chk("fs_count", c, 2);

        // Output exclusivity over the whole trace
        v = 0;
        for (int i = 0; i < NC; i++) begin
            if (a_lat[i] == 1 && a_clk[i] == 1) v++;
            if (a_lat[i] == 1 && a_oe[i] == 0) v++;
        end
        chk("lat_clk_oe_excl", v, 0);

        // rgb seen at each panel_clk pulse follows columns 0..3 per plane
        k = 0;
        n = 0;
        for (int i = 0; i < NC; i++) begin
            if (a_clk[i] == 1) begin
                chk($sformatf("rgb_c%0d", i), a_rgb[i], a_sel[i] * 4 + k);
                k = (k + 1) % 4;
                n++;
            end
        end
        chk("pclk_total", n, 20);

        // Reset in the middle of a row 1 shift
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (row == 1'b1 && go && col == 2'd1) found = 1'b1;
        end
        chk("rst_wait_found", int'(found), 1);
        chk("mid_oe_lit", int'(panel_oe_n), (LOW1 > 0) ? 0 : 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_oe_n", int'(panel_oe_n), 1);
        chk("mid_rst_row_col", int'({row, col, select}), 0);
        chk("mid_rst_go_fs", int'({go, frame_start, panel_clk, panel_lat}), 0);
        chk("mid_rst_addr", int'(panel_addr), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_fs", int'(frame_start), 1);
        chk("restart_go", int'(go), 1);
        chk("restart_row_sel", int'({row, select}), 0);
        chk("restart_oe_n", int'(panel_oe_n), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_driver_scan_ctrl.md
Name: display_driver_scan_ctrl

Overview:
- Scan sequencer for a HUB75-style panel.
- Drives the address, bit-plane select and go inputs of display_driver_rgb_pipe, which sits directly downstream of it.
- Generates panel_clk, panel_lat and panel_oe_n aligned to the pipe's rgb output, compensating for the pipe latency.
- Implements binary-coded modulation: the display period of plane p is oe_base<<p cycles. The next plane shifts in while the current plane is displayed.

Parameters:
- columns, 64, pixels shifted per row per plane
- rows, 16, scan rows (panel address count)
- bitwidth, 8, bit planes per colour channel
- pipe_length, 2, latency of the downstream rgb pipe in go-advances
- oe_base, 16, display cycles for plane 0

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- col  output  $clog2(columns)  column address to pixel fetch / pipe
- row  output  $clog2(rows)  row being shifted (to pixel fetch)
- select  output  $clog2(bitwidth)  bit plane being shifted (to pipe select)
- go  output  1  pipe advance strobe
- panel_clk  output  1  panel shift clock
- panel_lat  output  1  panel latch
- panel_oe_n  output  1  panel output enable, active low
- panel_addr  output  $clog2(rows)  row currently displayed
- frame_start  output  1  one-cycle pulse when the shift of row 0 plane 0 begins

Behaviour:
- One clock; reset is synchronous and active-high on rst.
- Reset values: col=0, row=0, select=0, go=0, panel_clk=0, panel_lat=0, panel_oe_n=1, panel_addr=0, frame_start=0. The OE timer is cleared to 0 and the FSM goes to SHIFT.
- Reset asserted mid-operation: all outputs take reset values the cycle after; scanning restarts at row 0 plane 0 and frame_start fires when SHIFT begins.
- FSM states: SHIFT -> WAIT -> BLANK -> LATCH -> SHIFT.
- SHIFT:
  - Lasts 2*(columns+pipe_length) cycles, made of slots of 2 cycles (phase 0, phase 1).
  - go=1 in phase 0 only, 0 in phase 1.
  - In slot k (k<columns), col=k; in the drain slots (k>=columns), col holds columns-1.
  - panel_clk=1 during phase 0 of slots pipe_length .. columns+pipe_length-1, giving exactly columns pulses.
  - Each rising edge of panel_clk falls mid-way in a 2-cycle window where rgb is stable and holds the column data, in order 0..columns-1.
- WAIT: hold all shift outputs (go=0, panel_clk=0). Exit to BLANK on the first cycle the OE timer is 0. If the timer is already 0, WAIT lasts exactly 1 cycle.
- BLANK: panel_oe_n=1, 1 cycle.
- LATCH:
  - panel_lat=1 and panel_oe_n=1 for 1 cycle.
  - panel_addr<=row and the OE timer loads oe_base<<select on the cycle after.
  - Then row/select advance: select+1; when select wraps from bitwidth-1 to 0, row+1; row wraps from rows-1 to 0.
- OE timer:
  - Width $clog2(oe_base)+bitwidth.
  - While nonzero, panel_oe_n=0 and the timer decrements each cycle, giving exactly oe_base<<p low cycles for plane p.
  - Runs concurrently with SHIFT.
- frame_start pulses on the first cycle of SHIFT when row=0 and select=0, including after reset.
- panel_lat and panel_clk are never 1 in the same cycle. panel_oe_n is 1 whenever panel_lat=1.

Optional Feature:
- Macro: SCAN_CTRL_BRIGHTNESS_EN.
- When defined:
  - Adds input brightness [7:0].
  - On load, the timer keeps period P=oe_base<<p, but panel_oe_n=0 only for the first (P*brightness)>>8 cycles and is 1 for the remaining cycles.
  - brightness is sampled at LATCH.
  - brightness=0 keeps the panel dark while preserving scan timing.
- When undefined: no brightness port; OE is low for the full P cycles.

Test Plan:
- Parameters for all scenarios: columns=4, rows=2, bitwidth=2, pipe_length=2, oe_base=16.
- Reset then run: first SHIFT lasts 12 cycles; go pulses 6 times on alternate cycles; col sequence 0,1,2,3,3,3; panel_clk pulses 4 times, first in slot 2; frame_start pulses once on cycle 0.
- After the first shift: WAIT lasts 1 cycle, BLANK 1, LATCH 1 (panel_lat=1, panel_oe_n=1). Then panel_addr=0 and panel_oe_n=0 for exactly 16 cycles, while SHIFT of plane 1 (select=1) runs.
- Plane 1 latch occurs after the 16-cycle timer expires (WAIT>1 cycle). OE is then low for exactly 32 cycles; next shift is row=1 select=0; after its latch panel_addr=1. After row 1 plane 1, row wraps to 0 and frame_start pulses again.
- Assert rst for 1 cycle mid-SHIFT of row 1: outputs return to reset values (panel_oe_n=1) the next cycle and scan restarts at row 0 select 0 with frame_start.
- Connect a display_driver_rgb_pipe (pipe_length=2) with a pixel source of column index parity. Sample rgb on panel_clk rising edges and check the sequence matches columns 0..3 for each plane.
- With SCAN_CTRL_BRIGHTNESS_EN and brightness=128: plane 0 OE low for 8 cycles then high for 8 cycles. With brightness=0, panel_oe_n stays 1 and latch timing is unchanged.
